// File: rtl/pipelined_ripple_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_ripple_adder_pkg : shared defaults and chunk-size helpers       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pipelined_ripple_adder_pkg;

  localparam int c_default_width  = 16;
  localparam int c_default_stages = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_ripple_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_ripple_adder_if : operand/result valid-ready bus                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pipelined_ripple_adder_if
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH = c_default_width
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface
`default_nettype wire

// File: rtl/pipelined_ripple_adder_full_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | full_adder : one-bit full adder cell                                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/pipelined_ripple_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_ripple_adder : chunked ripple-carry adder, one chunk per stage  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = c_default_width,
  parameter int STAGES = c_default_stages
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_ripple_adder_if.slave bus
);

  localparam int c_cw = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_ripple_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Inner stages carry operands forward; only the last stage is reset, as it drives the outputs.
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;
  logic             r_cmsb;
  logic             w_adv   [STAGES];
  logic             w_ld    [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_up_valid;
    logic [WIDTH-1:0] w_a_src;
    logic [WIDTH-1:0] w_b_src;
    logic [WIDTH-1:0] w_sum_src;
    logic             w_cin_src;
    logic [c_cw:0]    w_c;
    logic [c_cw-1:0]  w_s;
    logic [WIDTH-1:0] w_sum_nxt;

    if (k == 0) begin : g_head
      assign w_up_valid = bus.in_valid;
      assign w_a_src    = bus.a;
      assign w_b_src    = bus.b;
      assign w_sum_src  = '0;
      assign w_cin_src  = bus.cin;
    end else begin : g_body
      assign w_up_valid = r_valid[k-1];
      assign w_a_src    = r_a[k-1];
      assign w_b_src    = r_b[k-1];
      assign w_sum_src  = r_sum[k-1];
      assign w_cin_src  = r_carry[k-1];
    end

    // A stage can load when empty or when its occupant moves on this edge.
    if (k == STAGES-1) begin : g_tail_hs
      assign w_adv[k] = r_valid[k] & bus.out_ready;
    end else begin : g_mid_hs
      assign w_adv[k] = r_valid[k] & (~r_valid[k+1] | w_adv[k+1]);
    end
    assign w_ld[k] = ~r_valid[k] | w_adv[k];

    assign w_c[0] = w_cin_src;
    for (genvar j = 0; j < c_cw; j++) begin : g_fa
      full_adder u_fa (
        .a   (w_a_src[k*c_cw + j]),
        .b   (w_b_src[k*c_cw + j]),
        .cin (w_c[j]),
        .s   (w_s[j]),
        .cout(w_c[j+1])
      );
    end

    always_comb begin
      w_sum_nxt                 = w_sum_src;
      w_sum_nxt[k*c_cw +: c_cw] = w_s;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid[k] <= 1'b0;
      end else if (w_ld[k]) begin
        r_valid[k] <= w_up_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (w_ld[k] && w_up_valid) begin
        r_a[k] <= w_a_src;
        r_b[k] <= w_b_src;
      end
    end

    if (k == STAGES-1) begin : g_tail_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum_out <= '0;
          r_cout    <= 1'b0;
          r_cmsb    <= 1'b0;
        end else if (w_ld[k] && w_up_valid) begin
          r_sum_out <= w_sum_nxt;
          r_cout    <= w_c[c_cw];
          r_cmsb    <= w_c[c_cw-1];
        end
      end
    end else begin : g_mid_reg
      always_ff @(posedge clk) begin
        if (w_ld[k] && w_up_valid) begin
          r_sum[k]   <= w_sum_nxt;
          r_carry[k] <= w_c[c_cw];
        end
      end
    end
  end

  assign bus.in_ready  = w_ld[0];
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sum       = r_sum_out;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_cout ^ r_cmsb;

endmodule
`default_nettype wire
